vector_logic_gate: RTL
======================

VECTOR_LOGIC_GATE -- requirements
Module: vector_logic_gate

Interface
REQ-001 Parameter DATA_SIZE, default 64, width of each operand element and of SIZE_IN.
REQ-002 Parameter CONTROL_SIZE, default 3, width of OPERATION.
REQ-003 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset: synchronous, active-low; sampled only on CLK rising edge.
REQ-005 Port START  input  1  one-cycle request to begin a vector operation.
REQ-006 Port READY  output  1  one-cycle pulse: last element of the vector has been output.
REQ-007 Port OPERATION  input  CONTROL_SIZE  gate select, latched on accepted START.
REQ-008 Port SIZE_IN  input  DATA_SIZE  vector length in elements, latched on accepted START.
REQ-009 Port DATA_A_IN_ENABLE  input  1  DATA_A_IN valid this cycle.
REQ-010 Port DATA_B_IN_ENABLE  input  1  DATA_B_IN valid this cycle.
REQ-011 Port DATA_A_IN  input  DATA_SIZE  operand A element.
REQ-012 Port DATA_B_IN  input  DATA_SIZE  operand B element.
REQ-013 Port DATA_OUT_ENABLE  output  1  one-cycle pulse: DATA_OUT holds a new result element.
REQ-014 Port DATA_OUT  output  DATA_SIZE  registered result element.

Function
REQ-015 FSM states SHALL be STARTER_STATE (idle), INPUT_STATE (collect operand pair), ENDER_STATE (compute/emit).
REQ-016 STARTER_STATE: START=1 SHALL latch OPERATION, SIZE_IN, clear element index to 0, clear A/B captured flags, go to INPUT_STATE; START=0 stays.
REQ-017 START outside STARTER_STATE SHALL be ignored; latched OPERATION/SIZE_IN unchanged.
REQ-018 INPUT_STATE: DATA_A_IN_ENABLE=1 SHALL register DATA_A_IN and set A flag; likewise B; later enable for an already-captured operand overwrites it.
REQ-019 INPUT_STATE SHALL go to ENDER_STATE on the edge where both operands are captured (same cycle or any order across cycles).
REQ-020 Operand enables in STARTER_STATE or ENDER_STATE SHALL be ignored.
REQ-021 ENDER_STATE (one cycle): DATA_OUT <= f(A,B) bitwise, DATA_OUT_ENABLE <= 1, flags cleared.
REQ-022 f by OPERATION: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 A pass-through; all bitwise over DATA_SIZE bits.
REQ-023 ENDER_STATE: if index = SIZE_IN-1 then READY <= 1 and next STARTER_STATE; else index <= index+1, next INPUT_STATE.
REQ-024 SIZE_IN = 0 SHALL be treated as 1 (one element, then READY).
REQ-025 Latency: enables completing pair sampled at edge k -> DATA_OUT/DATA_OUT_ENABLE visible after edge k+1; back-to-back pairs every 2 cycles max.
REQ-026 DATA_OUT_ENABLE and READY SHALL be high exactly one cycle; DATA_OUT SHALL hold its value until the next result or reset.
REQ-027 READY and final DATA_OUT_ENABLE SHALL assert in the same cycle.
REQ-028 Index SHALL be DATA_SIZE bits; never wraps because completion occurs at SIZE_IN-1.

Reset
REQ-029 RST=0 at a rising edge SHALL force STARTER_STATE, index 0, flags 0, READY 0, DATA_OUT_ENABLE 0, DATA_OUT 0, latched OPERATION/SIZE_IN 0.
REQ-030 RST=0 SHALL take priority over START and all enables; reset mid-vector aborts with no READY and no further DATA_OUT_ENABLE.
REQ-031 Asynchronous RST changes between edges SHALL have no effect on state or outputs.

Verification
REQ-032 NOR, SIZE_IN=1, DATA_SIZE=64: A=0x00FF, B=0x0F00, both enables same cycle -> 2 cycles later DATA_OUT=0xFFFF_FFFF_FFFF_F000, DATA_OUT_ENABLE=1, READY=1, both one cycle only.
REQ-033 XOR, SIZE_IN=3, pairs (1,3),(5,5),(0xF0,0x0F) -> DATA_OUT 2, 0, 0xFF with three DATA_OUT_ENABLE pulses; READY only with third.
REQ-034 AND, SIZE_IN=1: A enabled cycle 1 (0xFF), B enabled cycle 4 (0x3C) -> no output before B; DATA_OUT=0x3C one cycle after ENDER entry; second A enable before B replaces A.
REQ-035 START re-asserted mid-vector with OPERATION=001 -> ignored; results still use latched opcode; SIZE_IN=0 run yields one result plus READY.
REQ-036 RST=0 during INPUT_STATE of a SIZE_IN=4 vector after 2 results -> next cycle all outputs 0, no READY; new START runs a fresh 4-element vector correctly.
REQ-037 RST deasserted-low glitch between clock edges -> no state change; outputs unaffected.

Source files
------------

// File: rtl/vector_logic_gate.sv
// Element-wise bitwise logic over a vector of operand pairs.
// Each pair is collected in any order, then one result is emitted per pair.
module vector_logic_gate #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] OPERATION,
    input  logic [DATA_SIZE-1:0]    SIZE_IN,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    typedef enum logic [1:0] {
        STARTER_STATE,
        INPUT_STATE,
        ENDER_STATE
    } state_t;

    state_t                  state;
    logic [CONTROL_SIZE-1:0] operation_r;
    logic [DATA_SIZE-1:0]    size_r;
    logic [DATA_SIZE-1:0]    index;
    logic [DATA_SIZE-1:0]    last_index;
    logic [DATA_SIZE-1:0]    data_a;
    logic [DATA_SIZE-1:0]    data_b;
    logic [DATA_SIZE-1:0]    gate_result;
    logic                    data_a_flag;
    logic                    data_b_flag;
    logic                    pair_done;

    // A zero-length request still produces exactly one element.
    always_comb begin
        last_index = '0;
        if (size_r != '0)
            last_index = size_r - DATA_SIZE'(1);
    end

    always_comb begin
        gate_result = '0;
        case (operation_r)
            CONTROL_SIZE'(0): gate_result = data_a & data_b;
            CONTROL_SIZE'(1): gate_result = data_a | data_b;
            CONTROL_SIZE'(2): gate_result = data_a ^ data_b;
            CONTROL_SIZE'(3): gate_result = ~(data_a & data_b);
            CONTROL_SIZE'(4): gate_result = ~(data_a | data_b);
            CONTROL_SIZE'(5): gate_result = ~(data_a ^ data_b);
            CONTROL_SIZE'(6): gate_result = ~data_a;
            default:          gate_result = data_a;
        endcase
    end

    assign pair_done = (data_a_flag | DATA_A_IN_ENABLE) & (data_b_flag | DATA_B_IN_ENABLE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state           <= STARTER_STATE;
            operation_r     <= '0;
            size_r          <= '0;
            index           <= '0;
            data_a          <= '0;
            data_b          <= '0;
            data_a_flag     <= 1'b0;
            data_b_flag     <= 1'b0;
            READY           <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            DATA_OUT        <= '0;
        end else begin
            READY           <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (START) begin
                        operation_r <= OPERATION;
                        size_r      <= SIZE_IN;
                        index       <= '0;
                        data_a_flag <= 1'b0;
                        data_b_flag <= 1'b0;
                        state       <= INPUT_STATE;
                    end
                end
                INPUT_STATE: begin
                    if (DATA_A_IN_ENABLE) begin
                        data_a      <= DATA_A_IN;
                        data_a_flag <= 1'b1;
                    end
                    if (DATA_B_IN_ENABLE) begin
                        data_b      <= DATA_B_IN;
                        data_b_flag <= 1'b1;
                    end
                    if (pair_done)
                        state <= ENDER_STATE;
                end
                ENDER_STATE: begin
                    DATA_OUT        <= gate_result;
                    DATA_OUT_ENABLE <= 1'b1;
                    data_a_flag     <= 1'b0;
                    data_b_flag     <= 1'b0;
                    if (index == last_index) begin
                        READY <= 1'b1;
                        state <= STARTER_STATE;
                    end else begin
                        index <= index + DATA_SIZE'(1);
                        state <= INPUT_STATE;
                    end
                end
                default: state <= STARTER_STATE;
            endcase
        end
    end

endmodule
